// File: rtl/serial_parity_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : serial_parity_arbiter                                          |
// | Brief   : Round-robin arbiter for two frame requesters; serialises the   |
// |           winning frame LSB-first and reports its odd/even parity.       |
// |           Optional macro SERIAL_PARITY_ERR_CNT_EN adds err_cnt output.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module serial_parity_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
`ifdef SERIAL_PARITY_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              busy,
    output logic              dout,
    output logic              dout_valid,
    output logic              done,
    output logic              owner,
    output logic              parity_odd
);

    localparam int c_cnt_w = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic                par_q, par_d;
    logic                last_q, last_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                busy_q, busy_d;
    logic                dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                done_q, done_d;
    logic                owner_q, owner_d;
    logic                parity_odd_q, parity_odd_d;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [7:0]          err_cnt_q, err_cnt_d;
`endif

    logic                w_win;
    logic [DATA_W-1:0]   w_sel;

    // On a tie the requester that was not served last wins.
    assign w_win = (req0 && req1) ? ~last_q : req1;
    assign w_sel = w_win ? data1 : data0;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        par_d        = par_q;
        last_d       = last_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        busy_d       = busy_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        done_d       = 1'b0;
        owner_d      = owner_q;
        parity_odd_d = parity_odd_q;
`ifdef SERIAL_PARITY_ERR_CNT_EN
        err_cnt_d    = err_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d      = SHIFT;
                    shift_d      = w_sel >> 1;
                    dout_d       = w_sel[0];
                    dout_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    gnt0_d       = ~w_win;
                    gnt1_d       = w_win;
                    owner_d      = w_win;
                    last_d       = w_win;
                    cnt_d        = '0;
                    par_d        = 1'b0;
                end
            end
            SHIFT: begin
                // par_q accumulates every bit already presented on dout.
                par_d = par_q ^ dout_q;
                if (cnt_q == c_last) begin
                    state_d      = DONE;
                    dout_d       = 1'b0;
                    dout_valid_d = 1'b0;
                    done_d       = 1'b1;
                    parity_odd_d = par_q ^ dout_q;
`ifdef SERIAL_PARITY_ERR_CNT_EN
                    if ((par_q ^ dout_q) && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
`endif
                end else begin
                    cnt_d   = cnt_q + c_cnt_w'(1);
                    dout_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d      = IDLE;
                busy_d       = 1'b0;
                dout_d       = 1'b0;
                dout_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            par_q        <= 1'b0;
            last_q       <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            busy_q       <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
            owner_q      <= 1'b0;
            parity_odd_q <= 1'b0;
`ifdef SERIAL_PARITY_ERR_CNT_EN
            err_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            par_q        <= par_d;
            last_q       <= last_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            busy_q       <= busy_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
            owner_q      <= owner_d;
            parity_odd_q <= parity_odd_d;
`ifdef SERIAL_PARITY_ERR_CNT_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign busy       = busy_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign done       = done_q;
    assign owner      = owner_q;
    assign parity_odd = parity_odd_q;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    assign err_cnt    = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_serial_parity_arbiter                                       |
// | Brief   : Scoreboard bench for serial_parity_arbiter (directed frames).  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_serial_parity_arbiter;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1;
    logic [DATA_W-1:0] data0, data1;
    logic              gnt0, gnt1, busy, dout, dout_valid, done, owner, parity_odd;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    serial_parity_arbiter #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .data0      (data0),
        .data1      (data1),
`ifdef SERIAL_PARITY_ERR_CNT_EN
        .err_cnt    (err_cnt),
`endif
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .done       (done),
        .owner      (owner),
        .parity_odd (parity_odd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              owner;
        logic [DATA_W-1:0] data;
        logic              par;
        logic              gap_chk;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_done_cyc = 0;
    int   nbits    = 0;
    int   exp_err  = 0;
    logic [DATA_W-1:0] got;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic o, input logic [DATA_W-1:0] d, input logic p, input logic g);
        exp_t e;
        e.owner = o; e.data = d; e.par = p; e.gap_chk = g;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: reconstructs each serial frame and pops the scoreboard on done.
    always @(negedge clk) begin
        if (reset) begin
            nbits   = 0;
            got     = '0;
            exp_err = 0;
        end else begin
            chk("gnt_exclusive", int'(gnt0 && gnt1), 0);
            chk("dout_idle_zero", int'(!dout_valid && dout), 0);
            if (gnt0 || gnt1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", 1, 0);
                end else begin
                    chk("gnt_owner", int'(gnt1), int'(exp_q[0].owner));
                    chk("owner_at_gnt", int'(owner), int'(exp_q[0].owner));
                    chk("busy_at_gnt", int'(busy), 1);
                    if (exp_q[0].gap_chk) chk("idle_gap", cyc - last_done_cyc, 2);
                end
                nbits = 0;
                got   = '0;
            end
            if (dout_valid) begin
                if (nbits < DATA_W) got[nbits] = dout;
                nbits++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("bit_count", nbits, DATA_W);
                    chk("serial_data", int'(got), int'(exp_q[0].data));
                    chk("parity_odd", int'(parity_odd), int'(exp_q[0].par));
                    chk("owner_at_done", int'(owner), int'(exp_q[0].owner));
                    chk("busy_at_done", int'(busy), 1);
`ifdef SERIAL_PARITY_ERR_CNT_EN
                    if (exp_q[0].par && exp_err < 255) exp_err++;
                    chk("err_cnt", int'(err_cnt), exp_err);
`endif
                    void'(exp_q.pop_front());
                end
                last_done_cyc = cyc;
                nbits = 0;
            end
        end
    end

    task automatic wait_gnts(input int n);
        int seen   = 0;
        int budget = n * (DATA_W + 4) + 20;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (gnt0 || gnt1) seen++;
            budget--;
        end
        chk("gnt_count", seen, n);
    endtask

    task automatic wait_empty();
        int budget = 4 * DATA_W + 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("queue_drain", exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"}, int'(gnt0), 0);
        chk({tag, "_gnt1"}, int'(gnt1), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_dout"}, int'(dout), 0);
        chk({tag, "_dout_valid"}, int'(dout_valid), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_owner"}, int'(owner), 0);
        chk({tag, "_parity_odd"}, int'(parity_odd), 0);
`ifdef SERIAL_PARITY_ERR_CNT_EN
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        data0 = '0;  data1 = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Tie after reset: 0,1,0,1 with one IDLE cycle between frames.
        push(1'b0, 8'h5A, 1'b0, 1'b0);
        push(1'b1, 8'h31, 1'b1, 1'b1);
        push(1'b0, 8'h5A, 1'b0, 1'b1);
        push(1'b1, 8'h31, 1'b1, 1'b1);
        data0 = 8'h5A; data1 = 8'h31;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnts(4);
        req0 = 1'b0; req1 = 1'b0;
        wait_empty();

        // Single frames.
        push(1'b0, 8'hB4, 1'b0, 1'b0);
        data0 = 8'hB4; req0 = 1'b1;
        wait_gnts(1);
        req0 = 1'b0;
        wait_empty();

        push(1'b1, 8'h07, 1'b1, 1'b0);
        data1 = 8'h07; req1 = 1'b1;
        wait_gnts(1);
        req1 = 1'b0;
        wait_empty();
        chk("parity_held", int'(parity_odd), 1);

        // Abort a frame from requester 0 in its 4th SHIFT cycle.
        push(1'b0, 8'hFF, 1'b0, 1'b0);
        data0 = 8'hFF; req0 = 1'b1;
        wait_gnts(1);
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("no_done_after_abort", done_seen, 0);

        // Pointer must be back at requester 0 despite the aborted capture.
        push(1'b0, 8'h3C, 1'b0, 1'b0);
        push(1'b1, 8'h80, 1'b1, 1'b1);
        data0 = 8'h3C; data1 = 8'h80;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnts(2);
        req0 = 1'b0; req1 = 1'b0;
        wait_empty();

`ifdef SERIAL_PARITY_ERR_CNT_EN
        push(1'b0, 8'h01, 1'b1, 1'b0);
        for (int i = 1; i < 260; i++) push(1'b0, 8'h01, 1'b1, 1'b1);
        data0 = 8'h01; req0 = 1'b1;
        wait_gnts(260);
        req0 = 1'b0;
        wait_empty();
        chk("err_cnt_saturated", int'(err_cnt), 255);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_parity_arbiter.md
SERIAL_PARITY_ARBITER -- requirements
Module: serial_parity_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning frame width in bits (legal 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0 / req1  input  1  frame request from requester 0 / 1; held high until gnt seen.
REQ-005 SHALL have ports data0 / data1  input  DATA_W  frame payload; stable while matching req high.
REQ-006 SHALL have ports gnt0 / gnt1  output  1  one-cycle accept pulse to requester 0 / 1.
REQ-007 SHALL have port busy  output  1  high in SHIFT and DONE states.
REQ-008 SHALL have ports dout / dout_valid  output  1 / 1  serial bit to shared odd/even detector, and its qualifier.
REQ-009 SHALL have port done  output  1  one-cycle pulse: frame result valid.
REQ-010 SHALL have port owner  output  1  index of requester owning current/last frame.
REQ-011 SHALL have port parity_odd  output  1  1 = odd number of 1s in last completed frame; held until next done.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-013 IDLE: SHALL stay in IDLE while req0=req1=0.
REQ-014 IDLE with any req: SHALL pick winner, load its data into shift register, set owner, go to SHIFT on that edge.
REQ-015 Arbitration SHALL be round-robin: single request wins outright; on tie, the requester not served last wins.
REQ-016 gntN SHALL be high only for the first SHIFT cycle, for the winner only; never both gnt0 and gnt1 high.
REQ-017 SHIFT: SHALL present shift_reg LSB on dout with dout_valid=1 for exactly DATA_W consecutive cycles, LSB-first.
REQ-018 SHALL hold an internal Moore parity state EVEN/ODD: cleared to EVEN on capture, toggled each SHIFT cycle in which dout=1.
REQ-019 After the DATA_W-th bit SHALL enter DONE for exactly one cycle: done=1, parity_odd = final parity state, dout_valid=0.
REQ-020 DONE SHALL always return to IDLE; requests SHALL NOT be sampled in SHIFT or DONE.
REQ-021 Latency: capture edge in cycle T -> bits in cycles T+1..T+DATA_W -> done in cycle T+DATA_W+1; next capture earliest at end of T+DATA_W+2.
REQ-022 Back-to-back requests SHALL thus be separated by one IDLE cycle; a losing request SHALL be served next, never starved.
REQ-023 dout SHALL be 0 whenever dout_valid=0.
REQ-024 Request dropped mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE; gnt0=gnt1=0, busy=0, dout=0, dout_valid=0, done=0, owner=0, parity_odd=0.
REQ-026 Round-robin pointer SHALL reset so that requester 0 wins the first tie.
REQ-027 Reset mid-frame SHALL abort the frame with no done pulse; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-028 Macro SERIAL_PARITY_ERR_CNT_EN defined: SHALL add output err_cnt, 8 bits, incremented on each done with parity_odd=1, saturating at 255, cleared by reset.
REQ-029 Macro SERIAL_PARITY_ERR_CNT_EN undefined: err_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Single frame: req0=1, data0=8'hB4 -> gnt0 one cycle, dout 0,0,1,0,1,1,0,1 over 8 cycles, done with parity_odd=0, owner=0.
REQ-031 Odd frame: req1=1, data1=8'h07 -> gnt1, 8 serial bits, done with parity_odd=1, owner=1; err_cnt=1 when macro on.
REQ-032 Tie after reset: req0=req1=1 held -> frames served 0,1,0,1 in order, one IDLE cycle between done and next gnt.
REQ-033 Reset mid-frame: reset asserted in 4th SHIFT cycle -> outputs zero immediately, no done, next tie grants requester 0.
REQ-034 Saturation (macro on): 260 frames of data0=8'h01 -> err_cnt stops at 255; macro off -> compiles without err_cnt.
